lsu_ctrl: RTL

- Load/store sequencing controller between the core's memory stage and a word-wide data-memory port with a request/grant/response handshake.
- Accepts one load or store at a time. Computes byte enables and lane-shifted write data.
- Splits misaligned accesses into two aligned word transactions, merges the returned bytes, and applies RV32I sign/zero extension before returning load data to writeback.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_ctrl_if.sv | 43 ++++
 rtl/lsu_lane.sv | 53 +++++
 rtl/lsu_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller.
// Holds RV32I funct3 encodings, the controller state encoding and the
// request decode helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == SB || f3 == SH || f3 == SW);
    return !(f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
  endfunction

  // funct3[1:0] is the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off == 2'd3;
      2'b10:   return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundles for the load/store controller.
// lsu_core_if: memory-stage request and one-cycle response (core = master).
// lsu_mem_if : word-wide data-memory port with req/gnt and rvalid (lsu = master).
interface lsu_core_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane datapath for the load/store controller (purely combinational).
// Ports: funct3/off select size and byte offset; wdata is the right-justified
// store data; lo_buf/hi_buf are the captured read beats. Outputs are the
// byte enables and write data for beat 1 and beat 2, and the merged,
// sign/zero-extended load result.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_buf,
  input  logic [31:0] hi_buf,
  output logic [3:0]  be1,
  output logic [3:0]  be2,
  output logic [31:0] wdata1,
  output logic [31:0] wdata2,
  output logic [31:0] rdata
);

  logic [3:0]  be_base;
  logic [2:0]  back;
  logic [31:0] raw;

  always_comb begin
    case (funct3[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end

  // Beat 2 carries whatever spilled past lane 3 in beat 1; for a halfword at
  // offset 3 this yields 0001, for a word 1111>>(4-o).
  assign back   = 3'd4 - {1'b0, off};
  assign be1    = be_base << off;
  assign be2    = be_base >> back;
  assign wdata1 = wdata << {off, 3'b000};
  assign wdata2 = wdata >> {back, 3'b000};

  assign raw = 32'({hi_buf, lo_buf} >> {off, 3'b000});

  always_comb begin
    case (funct3)
      LB:      rdata = {{24{raw[7]}}, raw[7:0]};
      LH:      rdata = {{16{raw[15]}}, raw[15:0]};
      LBU:     rdata = {24'h0, raw[7:0]};
      LHU:     rdata = {16'h0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: accepts one core access at a time,
// issues one or two aligned word transactions on the memory port, merges
// and extends load data, and returns a one-cycle response.
// Ports: clk, rst (sync, active-high); core (lsu_core_if.slave);
// mem (lsu_mem_if.master). SPLIT_MISALIGNED=0 turns misaligned accesses
// into error responses without touching memory.
//
// state | meaning
// IDLE  | ready for a new request
// REQ1  | first word request held until granted
// WAIT1 | waiting for first response beat
// REQ2  | second word request (misaligned split) held until granted
// WAIT2 | waiting for second response beat
// RESP  | one-cycle response to the core
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);

  lsu_state_e  state_q, state_d;
  logic        we_q, split_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q;
  logic [3:0]  be1, be2;
  logic [31:0] wdata1, wdata2, ext, base;
  logic        accept, mis, err_now;

  assign base    = {addr_q[31:2], 2'b00};
  assign mis     = is_misaligned(core.req_funct3, core.req_addr[1:0]);
  assign err_now = f3_illegal(core.req_we, core.req_funct3) || (mis && !SPLIT_MISALIGNED);
  assign accept  = (state_q == IDLE) && core.req_valid;

  lsu_lane u_lane (
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .lo_buf (lo_q),
    .hi_buf (hi_q),
    .be1    (be1),
    .be2    (be2),
    .wdata1 (wdata1),
    .wdata2 (wdata2),
    .rdata  (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      hi_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= core.req_we;
        f3_q    <= core.req_funct3;
        addr_q  <= core.req_addr;
        wdata_q <= core.req_wdata;
        err_q   <= err_now;
        split_q <= mis && SPLIT_MISALIGNED;
        // hi_q stays zero for single-beat accesses so the merge shift is uniform.
        lo_q    <= 32'h0;
        hi_q    <= 32'h0;
      end
      if (state_q == WAIT1 && mem.mem_rvalid) lo_q <= mem.mem_rdata;
      if (state_q == WAIT2 && mem.mem_rvalid) hi_q <= mem.mem_rdata;
    end
  end

  always_comb begin
    state_d        = state_q;
    core.req_ready = 1'b0;
    core.rsp_valid = 1'b0;
    core.rsp_err   = 1'b0;
    core.rsp_rdata = 32'h0;
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_be     = 4'b0000;
    mem.mem_addr   = 32'h0;
    mem.mem_wdata  = 32'h0;
    case (state_q)
      IDLE: begin
        core.req_ready = 1'b1;
        if (core.req_valid) state_d = err_now ? RESP : REQ1;
      end
      REQ1: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base;
        mem.mem_be    = be1;
        mem.mem_wdata = wdata1;
        if (mem.mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem.mem_rvalid) state_d = split_q ? REQ2 : RESP;
      end
      REQ2: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = we_q;
        mem.mem_addr  = base + 32'd4;
        mem.mem_be    = be2;
        mem.mem_wdata = wdata2;
        if (mem.mem_gnt) state_d = WAIT2;
      end
      WAIT2: begin
        if (mem.mem_rvalid) state_d = RESP;
      end
      RESP: begin
        core.rsp_valid = 1'b1;
        core.rsp_err   = err_q;
        core.rsp_rdata = (err_q || we_q) ? 32'h0 : ext;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
